// File: rtl/ram_bytewise_clr_pkg.sv
// Shared definitions for the byte-writable scratch RAM: clear-FSM state encoding
// and small elaboration-time helpers.
package ram_bytewise_clr_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } clr_state_t;

   function automatic int num_lanes(input int data_w, input int byte_w);
      return data_w / byte_w;
   endfunction

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/ram_bytewise_clr_if.sv
// Access bus of the scratch RAM: address/data/enables in, read data and status pulses out.
interface ram_bytewise_clr_if
   import ram_bytewise_clr_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int BYTE_W = 8,
   parameter int ADDR_W = 9
);
   localparam int NUM_LANES = num_lanes(DATA_W, BYTE_W);

   logic [ADDR_W-1:0]    addr;
   logic [DATA_W-1:0]    data_in;
   logic                 we;
   logic [NUM_LANES-1:0] be;
   logic                 re;
   logic [DATA_W-1:0]    data_out;
   logic                 rd_valid;
   logic                 addr_err;
   logic                 busy;

   modport master (
      output addr, data_in, we, be, re,
      input  data_out, rd_valid, addr_err, busy
   );

   modport slave (
      input  addr, data_in, we, be, re,
      output data_out, rd_valid, addr_err, busy
   );

endinterface

// File: rtl/ram_bytewise_clr_clear_ctrl.sv
// Post-reset clear sequencer: walks every implemented word once, requesting a zero write,
// and holds busy until the last word has been written.
module ram_bytewise_clr_clear_ctrl
   import ram_bytewise_clr_pkg::*;
#(
   parameter int ADDR_W         = 9,
   parameter int DEPTH          = 512,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam clr_state_t      RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
   // One extra counter bit keeps DEPTH == 2**ADDR_W representable.
   localparam logic [ADDR_W:0] LAST_WORD   = (ADDR_W + 1)'(DEPTH - 1);

   clr_state_t        state;
   clr_state_t        state_next;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RESET_STATE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      busy       = 1'b0;
      clr_we     = 1'b0;
      case (state)
         ST_CLEAR: begin
            busy   = 1'b1;
            clr_we = 1'b1;
            if (cnt == LAST_WORD) begin
               state_next = ST_READY;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + (ADDR_W + 1)'(1);
            end
         end
         ST_READY: begin
            state_next = ST_READY;
         end
         default: begin
            state_next = RESET_STATE;
         end
      endcase
   end

   assign clr_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/ram_bytewise_clr.sv
// Parametrised single-port RAM with per-byte write enables, registered read with valid
// strobe, out-of-range pulse and a hardware clear sequence after reset.
module ram_bytewise_clr
   import ram_bytewise_clr_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int BYTE_W         = 8,
   parameter int ADDR_W         = 9,
   parameter int DEPTH          = 512,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   ram_bytewise_clr_if.slave  bus
);

   localparam int              NUM_LANES = num_lanes(DATA_W, BYTE_W);
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              busy;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              in_range;
   logic              accepted;
   logic              user_wr;
   logic              user_rd;
   logic [DATA_W-1:0] data_out_q;
   logic              rd_valid_q;
   logic              addr_err_q;

   ram_bytewise_clr_clear_ctrl #(
      .ADDR_W         (ADDR_W),
      .DEPTH          (DEPTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_ctrl (
      .clk      (clk),
      .reset    (reset),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign in_range = {1'b0, bus.addr} < DEPTH_EXT;
   assign accepted = (bus.we | bus.re) & ~busy;
   assign user_wr  = bus.we & ~busy & in_range;
   assign user_rd  = bus.re & ~busy;

   // Storage is deliberately not reset; the clear sequencer zeroes it instead.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (user_wr) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (bus.be[i]) begin
               mem[bus.addr][i*BYTE_W +: BYTE_W] <= bus.data_in[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Reads sample the array before this edge's write lands, giving read-first behaviour.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         rd_valid_q <= user_rd;
         addr_err_q <= accepted & ~in_range;
         if (user_rd) begin
            data_out_q <= in_range ? mem[bus.addr] : '0;
         end
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.addr_err = addr_err_q;
   assign bus.busy     = busy;

endmodule

// File: tb/tb_ram_bytewise_clr.sv
// Scoreboard bench for the scratch RAM: a full-depth and a 300-word instance run side by side
// against a byte-array reference model.
module tb_ram_bytewise_clr;

   localparam int DW      = 16;
   localparam int BW      = 8;
   localparam int AW      = 9;
   localparam int DEPTH_A = 512;
   localparam int DEPTH_B = 300;

   typedef struct {
      int          cyc;
      logic        valid;
      logic        err;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   logic        s_we   [2];
   logic        s_re   [2];
   logic [8:0]  s_addr [2];
   logic [15:0] s_data [2];
   logic [1:0]  s_be   [2];

   logic [7:0]  model_mem [2][512][2];
   int          clear_left [2];
   int          depth_of [2];
   logic [15:0] hold [2];
   exp_t        q_a [$];
   exp_t        q_b [$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   ram_bytewise_clr_if #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW)) bus_a ();
   ram_bytewise_clr_if #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW)) bus_b ();

   assign bus_a.we      = s_we[0];
   assign bus_a.re      = s_re[0];
   assign bus_a.addr    = s_addr[0];
   assign bus_a.data_in = s_data[0];
   assign bus_a.be      = s_be[0];
   assign bus_b.we      = s_we[1];
   assign bus_b.re      = s_re[1];
   assign bus_b.addr    = s_addr[1];
   assign bus_b.data_in = s_data[1];
   assign bus_b.be      = s_be[1];

   ram_bytewise_clr #(
      .DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW), .DEPTH(DEPTH_A), .CLEAR_ON_RESET(1'b1)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   ram_bytewise_clr #(
      .DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW), .DEPTH(DEPTH_B), .CLEAR_ON_RESET(1'b1)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   function automatic logic busy_of(input int d);
      return (d == 0) ? bus_a.busy : bus_b.busy;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic set_op(input int d, input logic w, input logic r, input logic [8:0] a,
                         input logic [15:0] din, input logic [1:0] b);
      s_we[d]   = w;
      s_re[d]   = r;
      s_addr[d] = a;
      s_data[d] = din;
      s_be[d]   = b;
   endtask

   // Model restarts from a freshly cleared memory each time reset is released.
   task automatic start_clear();
      for (int d = 0; d < 2; d++) begin
         clear_left[d] = depth_of[d];
         for (int w = 0; w < 512; w++) begin
            model_mem[d][w][0] = 8'h00;
            model_mem[d][w][1] = 8'h00;
         end
      end
   endtask

   // One clock of traffic: predict each DUT's response, clock it, queue the prediction.
   task automatic apply_stimulus();
      exp_t e [2];
      logic push [2];
      logic ok;
      int   a;
      for (int d = 0; d < 2; d++) begin
         push[d] = 1'b0;
         check_output($sformatf("busy_dut%0d", d), {31'd0, busy_of(d)}, {31'd0, clear_left[d] > 0});
         if (clear_left[d] > 0) begin
            clear_left[d]--;
         end else if (s_we[d] || s_re[d]) begin
            a          = int'(s_addr[d]);
            ok         = a < depth_of[d];
            e[d].valid = s_re[d];
            e[d].err   = !ok;
            e[d].data  = (s_re[d] && ok) ? {model_mem[d][a][1], model_mem[d][a][0]} : 16'h0000;
            if (s_we[d] && ok) begin
               for (int l = 0; l < 2; l++) begin
                  if (s_be[d][l]) model_mem[d][a][l] = s_data[d][l*8 +: 8];
               end
            end
            push[d] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         if (push[d]) begin
            e[d].cyc = cyc;
            if (d == 0) q_a.push_back(e[d]);
            else        q_b.push_back(e[d]);
         end
         s_we[d] = 1'b0;
         s_re[d] = 1'b0;
      end
   endtask

   task automatic monitor_dut(input int d);
      logic        v;
      logic        er;
      logic [15:0] dout;
      exp_t        f;
      logic        have;
      v    = (d == 0) ? bus_a.rd_valid : bus_b.rd_valid;
      er   = (d == 0) ? bus_a.addr_err : bus_b.addr_err;
      dout = (d == 0) ? bus_a.data_out : bus_b.data_out;
      have = 1'b0;
      if (d == 0) begin
         if (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
            f    = q_a.pop_front();
            have = 1'b1;
         end
      end else begin
         if (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
            f    = q_b.pop_front();
            have = 1'b1;
         end
      end
      if (have) begin
         check_output($sformatf("latency_dut%0d", d), cyc, f.cyc);
         check_output($sformatf("rd_valid_dut%0d", d), {31'd0, v}, {31'd0, f.valid});
         check_output($sformatf("addr_err_dut%0d", d), {31'd0, er}, {31'd0, f.err});
         if (f.valid) hold[d] = f.data;
      end else begin
         check_output($sformatf("idle_pulses_dut%0d", d), {30'd0, v, er}, 32'd0);
      end
      check_output($sformatf("data_out_dut%0d", d), {16'd0, dout}, {16'd0, hold[d]});
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         monitor_dut(0);
         monitor_dut(1);
      end else begin
         hold[0] = 16'h0000;
         hold[1] = 16'h0000;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [8:0] ra;
      depth_of[0] = DEPTH_A;
      depth_of[1] = DEPTH_B;
      hold[0]     = 16'h0000;
      hold[1]     = 16'h0000;
      for (int d = 0; d < 2; d++) set_op(d, 1'b0, 1'b0, 9'h000, 16'h0000, 2'b00);
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      check_output("reset_busy_a",     {31'd0, bus_a.busy},     32'd1);
      check_output("reset_busy_b",     {31'd0, bus_b.busy},     32'd1);
      check_output("reset_rd_valid_a", {31'd0, bus_a.rd_valid}, 32'd0);
      check_output("reset_addr_err_a", {31'd0, bus_a.addr_err}, 32'd0);
      check_output("reset_data_out_a", {16'd0, bus_a.data_out}, 32'd0);
      check_output("reset_data_out_b", {16'd0, bus_b.data_out}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      start_clear();

      // Clear after power-up: busy is compared every cycle against the model countdown.
      for (int n = 0; n < 600 && (clear_left[0] > 0 || clear_left[1] > 0); n++) apply_stimulus();

      set_op(0, 1'b0, 1'b1, 9'h000, 16'h0000, 2'b00); apply_stimulus();
      set_op(0, 1'b0, 1'b1, 9'h1FF, 16'h0000, 2'b00); apply_stimulus();

      set_op(0, 1'b1, 1'b0, 9'h000, 16'hA5A5, 2'b11); apply_stimulus();
      set_op(0, 1'b0, 1'b1, 9'h000, 16'h0000, 2'b00); apply_stimulus();

      set_op(0, 1'b1, 1'b0, 9'h001, 16'hF0F0, 2'b11); apply_stimulus();
      set_op(0, 1'b1, 1'b0, 9'h001, 16'h1234, 2'b01); apply_stimulus();
      set_op(0, 1'b0, 1'b1, 9'h001, 16'h0000, 2'b00); apply_stimulus();
      set_op(0, 1'b1, 1'b0, 9'h001, 16'hFFFF, 2'b00); apply_stimulus();
      set_op(0, 1'b0, 1'b1, 9'h001, 16'h0000, 2'b00); apply_stimulus();

      set_op(0, 1'b1, 1'b1, 9'h1FF, 16'h5A5A, 2'b11); apply_stimulus();
      set_op(0, 1'b0, 1'b1, 9'h1FF, 16'h0000, 2'b00); apply_stimulus();

      set_op(1, 1'b1, 1'b0, 9'h12B, 16'h1111, 2'b11); apply_stimulus();
      set_op(1, 1'b1, 1'b0, 9'h12C, 16'hFFFF, 2'b11); apply_stimulus();
      set_op(1, 1'b0, 1'b1, 9'h12C, 16'h0000, 2'b00); apply_stimulus();
      set_op(1, 1'b0, 1'b1, 9'h12B, 16'h0000, 2'b00); apply_stimulus();
      set_op(1, 1'b0, 1'b1, 9'h1FF, 16'h0000, 2'b00); apply_stimulus();

      // Randomised back-to-back traffic on both instances, biased towards a few hot words
      // and, for the short instance, towards its out-of-range boundary.
      for (int n = 0; n < 500; n++) begin
         for (int d = 0; d < 2; d++) begin
            if ($urandom_range(0, 3) == 0) ra = 9'($urandom_range(0, 511));
            else if (d == 0)               ra = 9'($urandom_range(0, 15));
            else                           ra = 9'($urandom_range(290, 309));
            set_op(d, 1'($urandom), 1'($urandom), ra, 16'($urandom), 2'($urandom));
         end
         apply_stimulus();
      end
      apply_stimulus();

      // Reset mid-clear: the whole clear must repeat, and traffic during it must be ignored.
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      start_clear();
      for (int n = 0; n < 100; n++) apply_stimulus();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_output("midclear_reset_busy_a", {31'd0, bus_a.busy}, 32'd1);
      reset = 1'b1;
      start_clear();
      for (int n = 0; n < 600 && (clear_left[0] > 0 || clear_left[1] > 0); n++) begin
         for (int d = 0; d < 2; d++) begin
            set_op(d, 1'($urandom), 1'($urandom), 9'($urandom_range(0, 15)), 16'($urandom), 2'b11);
         end
         apply_stimulus();
      end
      for (int w = 0; w < 16; w++) begin
         set_op(0, 1'b0, 1'b1, 9'(w), 16'h0000, 2'b00);
         set_op(1, 1'b0, 1'b1, 9'(w), 16'h0000, 2'b00);
         apply_stimulus();
      end
      apply_stimulus();
      apply_stimulus();

      check_output("pending_dut0", q_a.size(), 32'd0);
      check_output("pending_dut1", q_b.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
